// File: rtl/mesh_term_fifo_bank_if.sv
// Terminal-side bus of the FIFO bank: per-channel push/pop/flush strobes,
// write data, and the fall-through head data plus status returned by the bank.
interface mesh_term_fifo_bank_if #(
    parameter int NCH    = 16,
    parameter int PKG_SZ = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NCH-1:0]        push_i;
    logic [NCH*PKG_SZ-1:0] data_i;
    logic [NCH-1:0]        pop_i;
    logic [NCH-1:0]        flush_i;
    logic [NCH*PKG_SZ-1:0] data_o;
    logic [NCH-1:0]        pndng_o;
    logic [NCH-1:0]        full_o;
    logic [NCH-1:0]        almost_full_o;
    logic [NCH*CW-1:0]     count_o;
    logic [NCH*CNT_W-1:0]  ovf_cnt_o;
    logic [NCH-1:0]        err_o;

    // Agent side: drives strobes and data, observes FIFO status.
    modport master (
        output push_i, data_i, pop_i, flush_i,
        input  data_o, pndng_o, full_o, almost_full_o, count_o, ovf_cnt_o, err_o
    );

    // FIFO bank side.
    modport slave (
        input  push_i, data_i, pop_i, flush_i,
        output data_o, pndng_o, full_o, almost_full_o, count_o, ovf_cnt_o, err_o
    );
endinterface

// File: rtl/mesh_term_fifo_bank.sv
// Bank of NCH independent first-word-fall-through FIFOs for mesh terminals.
// Each channel has its own pointers, occupancy, saturating overflow counter
// and a one-cycle error pulse for overflow or pop-on-empty.
module mesh_term_fifo_bank #(
    parameter int NCH       = 16,
    parameter int PKG_SZ    = 32,
    parameter int DEPTH     = 16,
    parameter int MODE      = 0,
    parameter int AF_MARGIN = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mesh_term_fifo_bank_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0]    AF_CNT    = CW'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] OVF_MAX   = '1;
    localparam bit               OVERWRITE = (MODE != 0);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PKG_SZ-1:0] r_mem [DEPTH];
            logic [AW-1:0]     r_rd_ptr;
            logic [AW-1:0]     r_wr_ptr;
            logic [CW-1:0]     r_cnt;
            logic [CNT_W-1:0]  r_ovf_cnt;
            logic              r_err;

            logic              w_push;
            logic              w_pop;
            logic              w_flush;
            logic              w_empty;
            logic              w_full;
            logic              w_do_push;
            logic              w_rd_adv;
            logic              w_pop_err;
            logic              w_ovf;
            logic [CW-1:0]     w_cnt_next;

            assign w_push  = bus.push_i[gi];
            assign w_pop   = bus.pop_i[gi];
            assign w_flush = bus.flush_i[gi];
            assign w_empty = (r_cnt == '0);
            assign w_full  = (r_cnt == FULL_CNT);

            // Decode the edge's action; flush masks everything else. A push on a
            // full channel only lands if a pop frees the slot or overwrite is on.
            always_comb begin
                w_pop_err  = 1'b0;
                w_ovf      = 1'b0;
                w_do_push  = 1'b0;
                w_rd_adv   = 1'b0;
                w_cnt_next = r_cnt;
                if (w_flush) begin
                    w_cnt_next = '0;
                end else begin
                    w_pop_err = w_pop & w_empty;
                    w_ovf     = w_push & w_full & ~w_pop;
                    w_do_push = w_push & (~w_full | w_pop | OVERWRITE);
                    w_rd_adv  = (w_pop & ~w_empty) | (w_ovf & OVERWRITE);
                    if (w_do_push && !w_rd_adv) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end else if (!w_do_push && w_rd_adv) begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
            end

            // Pointer, occupancy, overflow counter and error pulse state.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_rd_ptr  <= '0;
                    r_wr_ptr  <= '0;
                    r_cnt     <= '0;
                    r_ovf_cnt <= '0;
                    r_err     <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_next;
                    r_err <= w_pop_err | w_ovf;
                    if (w_flush) begin
                        r_rd_ptr <= '0;
                        r_wr_ptr <= '0;
                    end else begin
                        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (w_rd_adv)  r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                    if (w_ovf && (r_ovf_cnt != OVF_MAX)) begin
                        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
                    end
                end
            end

            // Storage write; contents are deliberately left out of reset.
            always_ff @(posedge clk_i) begin
                if (w_do_push) begin
                    r_mem[r_wr_ptr] <= bus.data_i[gi*PKG_SZ +: PKG_SZ];
                end
            end

            assign bus.data_o[gi*PKG_SZ +: PKG_SZ] = w_empty ? '0 : r_mem[r_rd_ptr];
            assign bus.pndng_o[gi]                 = ~w_empty;
            assign bus.full_o[gi]                  = w_full;
            assign bus.almost_full_o[gi]           = (r_cnt >= AF_CNT);
            assign bus.count_o[gi*CW +: CW]        = r_cnt;
            assign bus.ovf_cnt_o[gi*CNT_W +: CNT_W] = r_ovf_cnt;
            assign bus.err_o[gi]                   = r_err;
        end
    endgenerate
endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// Bench for mesh_term_fifo_bank: a reject-mode and an overwrite-mode bank share
// the same stimulus and are both checked every cycle against queue-based models,
// with directed sequences and a vector table for the corner cases.
module tb_mesh_term_fifo_bank;
    localparam int NCH       = 16;
    localparam int PKG_SZ    = 32;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 2;
    localparam int CNT_W     = 16;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [NCH-1:0]        push  = '0;
    logic [NCH-1:0]        pop   = '0;
    logic [NCH-1:0]        flush = '0;
    logic [NCH*PKG_SZ-1:0] din   = '0;

    mesh_term_fifo_bank_if #(.NCH(NCH), .PKG_SZ(PKG_SZ), .DEPTH(DEPTH), .CNT_W(CNT_W)) if0 ();
    mesh_term_fifo_bank_if #(.NCH(NCH), .PKG_SZ(PKG_SZ), .DEPTH(DEPTH), .CNT_W(CNT_W)) if1 ();

    assign if0.push_i  = push;
    assign if0.pop_i   = pop;
    assign if0.flush_i = flush;
    assign if0.data_i  = din;
    assign if1.push_i  = push;
    assign if1.pop_i   = pop;
    assign if1.flush_i = flush;
    assign if1.data_i  = din;

    mesh_term_fifo_bank #(.NCH(NCH), .PKG_SZ(PKG_SZ), .DEPTH(DEPTH), .MODE(0),
                          .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W))
        u_dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0));
    mesh_term_fifo_bank #(.NCH(NCH), .PKG_SZ(PKG_SZ), .DEPTH(DEPTH), .MODE(1),
                          .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W))
        u_dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: index m*NCH+c, m=0 reject mode, m=1 overwrite mode.
    logic [PKG_SZ-1:0] mq [2*NCH][$];
    int unsigned       movf [2*NCH];
    bit                merr [2*NCH];

    task automatic cmp(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2*NCH; k++) begin
            mq[k].delete();
            movf[k] = 0;
            merr[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) begin
                int k = m*NCH + c;
                bit e = 1'b0;
                logic [PKG_SZ-1:0] d = din[c*PKG_SZ +: PKG_SZ];
                if (flush[c]) begin
                    mq[k].delete();
                end else begin
                    if (pop[c]) begin
                        if (mq[k].size() > 0) void'(mq[k].pop_front());
                        else e = 1'b1;
                    end
                    if (push[c]) begin
                        if (mq[k].size() == DEPTH) begin
                            e = 1'b1;
                            if (movf[k] < 65535) movf[k]++;
                            if (m == 1) begin
                                void'(mq[k].pop_front());
                                mq[k].push_back(d);
                            end
                        end else begin
                            mq[k].push_back(d);
                        end
                    end
                end
                merr[k] = e;
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [NCH*PKG_SZ-1:0] e_data, a_data;
            logic [NCH-1:0]        e_pn, a_pn, e_fu, a_fu, e_af, a_af, e_er, a_er;
            logic [NCH*CW-1:0]     e_cnt, a_cnt;
            logic [NCH*CNT_W-1:0]  e_ovf, a_ovf;
            for (int c = 0; c < NCH; c++) begin
                int k  = m*NCH + c;
                int sz = mq[k].size();
                e_data[c*PKG_SZ +: PKG_SZ] = (sz > 0) ? mq[k][0] : '0;
                e_pn[c] = (sz != 0);
                e_fu[c] = (sz == DEPTH);
                e_af[c] = (sz >= DEPTH - AF_MARGIN);
                e_cnt[c*CW +: CW] = CW'(sz);
                e_ovf[c*CNT_W +: CNT_W] = CNT_W'(movf[k]);
                e_er[c] = merr[k];
            end
            if (m == 0) begin
                a_data = if0.data_o; a_pn = if0.pndng_o; a_fu = if0.full_o;
                a_af = if0.almost_full_o; a_cnt = if0.count_o; a_ovf = if0.ovf_cnt_o;
                a_er = if0.err_o;
            end else begin
                a_data = if1.data_o; a_pn = if1.pndng_o; a_fu = if1.full_o;
                a_af = if1.almost_full_o; a_cnt = if1.count_o; a_ovf = if1.ovf_cnt_o;
                a_er = if1.err_o;
            end
            cmp($sformatf("m%0d_data", m),  512'(a_data), 512'(e_data));
            cmp($sformatf("m%0d_pndng", m), 512'(a_pn),   512'(e_pn));
            cmp($sformatf("m%0d_full", m),  512'(a_fu),   512'(e_fu));
            cmp($sformatf("m%0d_af", m),    512'(a_af),   512'(e_af));
            cmp($sformatf("m%0d_count", m), 512'(a_cnt),  512'(e_cnt));
            cmp($sformatf("m%0d_ovf", m),   512'(a_ovf),  512'(e_ovf));
            cmp($sformatf("m%0d_err", m),   512'(a_er),   512'(e_er));
        end
    endtask

    // One clock: inputs set at the falling edge, model advanced at the rising
    // edge, outputs sampled 1 ns later.
    task automatic cyc(input logic [NCH-1:0] pu, input logic [NCH-1:0] po,
                       input logic [NCH-1:0] fl, input logic [NCH*PKG_SZ-1:0] d);
        @(negedge clk_i);
        push = pu; pop = po; flush = fl; din = d;
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic chop(input int ch, input bit pu, input bit po, input bit fl,
                        input logic [PKG_SZ-1:0] d);
        logic [NCH-1:0]        vpu = '0;
        logic [NCH-1:0]        vpo = '0;
        logic [NCH-1:0]        vfl = '0;
        logic [NCH*PKG_SZ-1:0] vd  = '0;
        vpu[ch] = pu; vpo[ch] = po; vfl[ch] = fl;
        vd[ch*PKG_SZ +: PKG_SZ] = d;
        cyc(vpu, vpo, vfl, vd);
    endtask

    typedef struct {
        bit                pu;
        bit                po;
        bit                fl;
        logic [PKG_SZ-1:0] d;
        int                exp_cnt;
        bit                exp_err;
        bit                exp_pndng;
        logic [PKG_SZ-1:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // Channel 7 corner cases, starting empty; expectations hold for both modes.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 32'h0};   // pop on empty
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,  0, 1'b0, 1'b0, 32'h0};   // err drops
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'hA1, 1, 1'b0, 1'b1, 32'hA1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hA2, 2, 1'b0, 1'b1, 32'hA1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'hA3, 2, 1'b0, 1'b1, 32'hA2};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hA4, 0, 1'b0, 1'b0, 32'h0};   // flush beats push
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'hA5, 1, 1'b1, 1'b1, 32'hA5};  // push+pop on empty
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 32'h0};

        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_all();

        // Fill ch3, watch almost-full/full, then drain in order.
        for (int i = 0; i < 16; i++) begin
            chop(3, 1'b1, 1'b0, 1'b0, 32'h100 + i);
            cmp("s2_af3",   512'(if0.almost_full_o[3]), 512'((i + 1) >= 14));
            cmp("s2_full3", 512'(if0.full_o[3]),        512'((i + 1) == 16));
        end
        for (int i = 0; i < 16; i++) begin
            cmp("s2_head3", 512'(if0.data_o[3*PKG_SZ +: PKG_SZ]), 512'(32'h100 + i));
            chop(3, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        cmp("s2_pndng3", 512'(if0.pndng_o[3]), 512'(1'b0));
        $display("seq ch3 fill/drain done");

        // Full ch0 of 0..15, then one extra push: reject vs overwrite.
        for (int i = 0; i < 16; i++) chop(0, 1'b1, 1'b0, 1'b0, i);
        chop(0, 1'b1, 1'b0, 1'b0, 32'hBEEF);
        cmp("s3_err0_m0", 512'(if0.err_o[0]),          512'(1'b1));
        cmp("s4_err0_m1", 512'(if1.err_o[0]),          512'(1'b1));
        cmp("s3_ovf0_m0", 512'(if0.ovf_cnt_o[CNT_W-1:0]), 512'(1));
        cmp("s4_ovf0_m1", 512'(if1.ovf_cnt_o[CNT_W-1:0]), 512'(1));
        for (int i = 0; i < 16; i++) begin
            cmp("s3_head0_m0", 512'(if0.data_o[PKG_SZ-1:0]), 512'(i));
            cmp("s4_head0_m1", 512'(if1.data_o[PKG_SZ-1:0]),
                512'((i < 15) ? (i + 1) : 32'hBEEF));
            chop(0, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        $display("seq ch0 overflow done");

        // Full ch5, then simultaneous push+pop twenty times.
        for (int i = 0; i < 16; i++) chop(5, 1'b1, 1'b0, 1'b0, 32'h500 + i);
        for (int i = 0; i < 20; i++) begin
            chop(5, 1'b1, 1'b1, 1'b0, 32'h600 + i);
            cmp("s5_cnt5", 512'(if0.count_o[5*CW +: CW]), 512'(16));
            cmp("s5_err5", 512'(if0.err_o[5]),            512'(1'b0));
        end
        for (int i = 0; i < 16; i++) chop(5, 1'b0, 1'b1, 1'b0, 32'h0);
        $display("seq ch5 push+pop at full done");

        for (int i = 0; i < 9; i++) begin
            chop(7, tbl[i].pu, tbl[i].po, tbl[i].fl, tbl[i].d);
            cmp($sformatf("tbl%0d_cnt", i),  512'(if0.count_o[7*CW +: CW]), 512'(tbl[i].exp_cnt));
            cmp($sformatf("tbl%0d_err", i),  512'(if1.err_o[7]),            512'(tbl[i].exp_err));
            cmp($sformatf("tbl%0d_pn", i),   512'(if0.pndng_o[7]),          512'(tbl[i].exp_pndng));
            cmp($sformatf("tbl%0d_data", i), 512'(if1.data_o[7*PKG_SZ +: PKG_SZ]),
                512'(tbl[i].exp_data));
            $display("vec %0d ch7 push=%0d pop=%0d flush=%0d cnt=%0d err=%0d",
                     i, tbl[i].pu, tbl[i].po, tbl[i].fl,
                     if0.count_o[7*CW +: CW], if1.err_o[7]);
        end

        // Random traffic: fill-biased then drain-biased phases.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 150; n++) begin
                logic [NCH-1:0]        rpu, rpo, rfl;
                logic [NCH*PKG_SZ-1:0] rd;
                for (int c = 0; c < NCH; c++) begin
                    rpu[c] = ($urandom_range(99) < ((ph % 2 == 0) ? 70 : 30));
                    rpo[c] = ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 70));
                    rfl[c] = ($urandom_range(99) < 2);
                    rd[c*PKG_SZ +: PKG_SZ] = $urandom;
                end
                cyc(rpu, rpo, rfl, rd);
            end
            $display("random phase %0d done", ph);
        end

        // Asynchronous reset in the middle of traffic.
        @(negedge clk_i);
        push = '1; pop = '0; flush = '0; din = {NCH{32'h5A5A_0000}};
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_i);
        push = '0;
        rst_i = 1'b1;
        #1;
        check_all();
        chop(2, 1'b1, 1'b1, 1'b0, 32'h77);
        cmp("rst_first_err2", 512'(if0.err_o[2]),   512'(1'b1));
        cmp("rst_first_cnt2", 512'(if0.count_o[2*CW +: CW]), 512'(1));
        chop(2, 1'b0, 1'b0, 1'b0, 32'h0);
        $display("seq reset mid-traffic done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
